// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the decoder's packed control word and the
// bit positions of the fields the hazard logic inspects.
package pipeline_pkg;

  localparam int unsigned CTRL_W = 40;
  localparam int unsigned REG_W  = 5;

  localparam int unsigned CAD_LSB      = 26;
  localparam int unsigned GP_WE_BIT    = 25;
  localparam int unsigned MEM_RREN_BIT = 15;
  localparam int unsigned RS_LSB       = 10;
  localparam int unsigned RT_LSB       = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [3:0]       af;
    logic             i;
    logic             alu_mux_sel;
    logic [2:0]       shift_type;
    logic [REG_W-1:0] cad;
    logic             gp_we;
    logic [1:0]       gp_mux_sel;
    logic [3:0]       bf;
    logic [1:0]       pc_mux_select;
    logic             mem_wren;
    logic             mem_rren;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load held in EX and the
// instruction waiting in ID.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_gp_we,
  input  logic             ex_mem_rren,
  input  logic [REG_W-1:0] ex_cad,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use
);

  // rt is compared even for instructions that do not read it; a spurious
  // bubble is cheaper than decoding operand usage here.
  always_comb begin
    load_use = ex_valid && ex_mem_rren && ex_gp_we && (ex_cad != REG_ZERO) &&
               id_valid && ((ex_cad == id_rs) || (ex_cad == id_rt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, EX-driven flush and
// load-use bubble insertion.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = pipeline_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  import pipeline_pkg::*;

  ctrl_t ctrl_q;
  logic  load_use;

  assign out_ctrl = ctrl_q;

  load_use_detect u_load_use_detect (
    .ex_valid    (out_valid),
    .ex_gp_we    (out_ctrl[GP_WE_BIT]),
    .ex_mem_rren (out_ctrl[MEM_RREN_BIT]),
    .ex_cad      (out_ctrl[CAD_LSB +: REG_W]),
    .id_valid    (in_valid),
    .id_rs       (in_ctrl[RS_LSB +: REG_W]),
    .id_rt       (in_ctrl[RT_LSB +: REG_W]),
    .load_use    (load_use)
  );

  always_comb begin
    hazard_stall = load_use && !flush;
    in_ready     = !flush && !load_use && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      ctrl_q       <= '0;
      out_rs_data  <= '0;
      out_rt_data  <= '0;
      out_imm      <= '0;
      out_pc       <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      ctrl_q      <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
    end else if (out_valid && !out_ready) begin
      // EX is stalled: hold the payload, even with a load-use pending.
    end else if (load_use) begin
      out_valid   <= 1'b0;
      ctrl_q      <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      if (bubble_count != '1) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end else begin
      out_valid   <= in_valid;
      ctrl_q      <= in_valid ? ctrl_t'(in_ctrl) : '0;
      out_rs_data <= in_valid ? in_rs_data : '0;
      out_rt_data <= in_valid ? in_rt_data : '0;
      out_imm     <= in_valid ? in_imm : '0;
      out_pc      <= in_valid ? in_pc : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand sequences for
// flush-over-hold and repeated load-use bubbles.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 40;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_rs_data, in_rt_data, in_imm, in_pc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_rs_data, out_rt_data, out_imm, out_pc;
  logic          hazard_stall;
  logic [NW-1:0] bubble_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm), .out_pc(out_pc),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst_n, iv, fl, ordy;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] pc;
    logic          chk_comb, exp_ir, exp_hs, exp_ov;
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_pc;
    logic [NW-1:0] exp_bc;
  } vec_t;

  vec_t vecs[$];

  // Control word built field by field: af, i, alu_mux_sel, shift_type, cad,
  // gp_we, gp_mux_sel, bf, pc_mux_select, mem_wren, mem_rren, rs, rt, rd.
  function automatic logic [CW-1:0] mk(input logic [3:0] af, input logic [4:0] cad,
                                       input logic gp_we, input logic mem_rren,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {af, 1'b0, 1'b0, 3'b000, cad, gp_we, 2'b00, 4'h0, 2'b00, 1'b0, mem_rren, rs, rt, 5'd0};
  endfunction

  function automatic vec_t mkv(input logic r, input logic iv, input logic fl, input logic ordy,
                               input logic [CW-1:0] c, input logic [DW-1:0] pc,
                               input logic cc, input logic ir, input logic hs, input logic ov,
                               input logic [CW-1:0] ec, input logic [DW-1:0] epc,
                               input logic [NW-1:0] bc);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.fl = fl; v.ordy = ordy; v.ctrl = c; v.pc = pc;
    v.chk_comb = cc; v.exp_ir = ir; v.exp_hs = hs; v.exp_ov = ov;
    v.exp_ctrl = ec; v.exp_pc = epc; v.exp_bc = bc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; in_valid = v.iv; flush = v.fl; out_ready = v.ordy;
    in_ctrl = v.ctrl; in_pc = v.pc;
    in_rs_data = v.pc + 32'd1; in_rt_data = v.pc + 32'd2; in_imm = v.pc + 32'd3;
    #1;
    if (v.chk_comb) begin
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(v.exp_ir));
      chk({tag, "_hazard_stall"}, 64'(hazard_stall), 64'(v.exp_hs));
    end
    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(v.exp_ov));
    chk({tag, "_out_ctrl"}, 64'(out_ctrl), 64'(v.exp_ctrl));
    chk({tag, "_out_pc"}, 64'(out_pc), 64'(v.exp_pc));
    chk({tag, "_out_rs"}, 64'(out_rs_data), v.exp_ov ? 64'(v.exp_pc + 32'd1) : 64'd0);
    chk({tag, "_out_rt"}, 64'(out_rt_data), v.exp_ov ? 64'(v.exp_pc + 32'd2) : 64'd0);
    chk({tag, "_out_imm"}, 64'(out_imm), v.exp_ov ? 64'(v.exp_pc + 32'd3) : 64'd0);
    chk({tag, "_bubble_count"}, 64'(bubble_count), 64'(v.exp_bc));
  endtask

  initial begin
    logic [CW-1:0] a, b, lw, u, u2, n, lw0, z, lwnr;
    a    = mk(4'd1, 5'd3,  1'b1, 1'b0, 5'd1, 5'd2);
    b    = mk(4'd2, 5'd4,  1'b1, 1'b0, 5'd3, 5'd5);
    lw   = mk(4'd3, 5'd8,  1'b1, 1'b1, 5'd1, 5'd0);
    u    = mk(4'd4, 5'd9,  1'b1, 1'b0, 5'd8, 5'd2);
    u2   = mk(4'd5, 5'd10, 1'b1, 1'b0, 5'd2, 5'd8);
    n    = mk(4'd6, 5'd11, 1'b1, 1'b0, 5'd1, 5'd2);
    lw0  = mk(4'd3, 5'd0,  1'b1, 1'b1, 5'd1, 5'd0);
    z    = mk(4'd4, 5'd9,  1'b1, 1'b0, 5'd0, 5'd2);
    lwnr = mk(4'd3, 5'd8,  1'b1, 1'b0, 5'd1, 5'd0);

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_pc = '0; in_rs_data = '0; in_rt_data = '0; in_imm = '0;

    //                 rst iv fl rdy ctrl  pc       cc ir hs ov exp_ctrl epc      bc
    // reset held with a valid ID instruction, then stream A,B,LW,N
    vecs.push_back(mkv(0, 1, 0, 1, a,    32'h100, 0, 0, 0, 0, '0,   32'h0,   0));
    vecs.push_back(mkv(0, 1, 0, 1, a,    32'h100, 1, 1, 0, 0, '0,   32'h0,   0));
    vecs.push_back(mkv(1, 1, 0, 1, a,    32'h100, 1, 1, 0, 1, a,    32'h100, 0));
    vecs.push_back(mkv(1, 1, 0, 1, b,    32'h104, 1, 1, 0, 1, b,    32'h104, 0));
    vecs.push_back(mkv(1, 1, 0, 1, lw,   32'h108, 1, 1, 0, 1, lw,   32'h108, 0));
    vecs.push_back(mkv(1, 1, 0, 1, n,    32'h110, 1, 1, 0, 1, n,    32'h110, 0));
    // load-use on rs, then on rt
    vecs.push_back(mkv(1, 1, 0, 1, lw,   32'h114, 1, 1, 0, 1, lw,   32'h114, 0));
    vecs.push_back(mkv(1, 1, 0, 1, u,    32'h118, 1, 0, 1, 0, '0,   32'h0,   1));
    vecs.push_back(mkv(1, 1, 0, 1, u,    32'h118, 1, 1, 0, 1, u,    32'h118, 1));
    vecs.push_back(mkv(1, 1, 0, 1, lw,   32'h11C, 1, 1, 0, 1, lw,   32'h11C, 1));
    vecs.push_back(mkv(1, 1, 0, 1, u2,   32'h120, 1, 0, 1, 0, '0,   32'h0,   2));
    vecs.push_back(mkv(1, 1, 0, 1, u2,   32'h120, 1, 1, 0, 1, u2,   32'h120, 2));
    // rejected: cad=0, mem_rren=0, no register match, ID not valid
    vecs.push_back(mkv(1, 1, 0, 1, lw0,  32'h124, 1, 1, 0, 1, lw0,  32'h124, 2));
    vecs.push_back(mkv(1, 1, 0, 1, z,    32'h128, 1, 1, 0, 1, z,    32'h128, 2));
    vecs.push_back(mkv(1, 1, 0, 1, lwnr, 32'h12C, 1, 1, 0, 1, lwnr, 32'h12C, 2));
    vecs.push_back(mkv(1, 1, 0, 1, u,    32'h130, 1, 1, 0, 1, u,    32'h130, 2));
    vecs.push_back(mkv(1, 1, 0, 1, lw,   32'h134, 1, 1, 0, 1, lw,   32'h134, 2));
    vecs.push_back(mkv(1, 1, 0, 1, n,    32'h138, 1, 1, 0, 1, n,    32'h138, 2));
    vecs.push_back(mkv(1, 1, 0, 1, lw,   32'h13C, 1, 1, 0, 1, lw,   32'h13C, 2));
    vecs.push_back(mkv(1, 0, 0, 1, u,    32'h140, 1, 1, 0, 0, '0,   32'h0,   2));
    // back-pressure with a pending load-use: hold 3 cycles, then one bubble
    vecs.push_back(mkv(1, 1, 0, 1, lw,   32'h144, 1, 1, 0, 1, lw,   32'h144, 2));
    vecs.push_back(mkv(1, 1, 0, 0, u,    32'h148, 1, 0, 1, 1, lw,   32'h144, 2));
    vecs.push_back(mkv(1, 1, 0, 0, u,    32'h148, 1, 0, 1, 1, lw,   32'h144, 2));
    vecs.push_back(mkv(1, 1, 0, 0, u,    32'h148, 1, 0, 1, 1, lw,   32'h144, 2));
    vecs.push_back(mkv(1, 1, 0, 1, u,    32'h148, 1, 0, 1, 0, '0,   32'h0,   3));
    vecs.push_back(mkv(1, 1, 0, 1, u,    32'h148, 1, 1, 0, 1, u,    32'h148, 3));
    // plain back-pressure without hazard
    vecs.push_back(mkv(1, 1, 0, 0, n,    32'h14C, 1, 0, 0, 1, u,    32'h148, 3));
    vecs.push_back(mkv(1, 1, 0, 1, n,    32'h14C, 1, 1, 0, 1, n,    32'h14C, 3));
    // flush drops ID instruction; flush masks a pending load-use
    vecs.push_back(mkv(1, 1, 1, 1, a,    32'h150, 1, 0, 0, 0, '0,   32'h0,   3));
    vecs.push_back(mkv(1, 1, 0, 1, lw,   32'h154, 1, 1, 0, 1, lw,   32'h154, 3));
    vecs.push_back(mkv(1, 1, 1, 1, u,    32'h158, 1, 0, 0, 0, '0,   32'h0,   3));
    vecs.push_back(mkv(1, 1, 0, 1, u,    32'h158, 1, 1, 0, 1, u,    32'h158, 3));
    // flush together with reset gives reset values
    vecs.push_back(mkv(0, 1, 1, 1, a,    32'h15C, 1, 0, 0, 0, '0,   32'h0,   0));
    vecs.push_back(mkv(1, 1, 0, 1, a,    32'h15C, 1, 1, 0, 1, a,    32'h15C, 0));

    foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

    // Flush wins over an EX stall.
    step("flush_hold", mkv(1, 1, 1, 0, b, 32'h160, 1, 0, 0, 0, '0, 32'h0, 0));

    // Repeated load-use pairs: one bubble each, counter steps by one.
    for (int k = 0; k < 5; k++) begin
      step($sformatf("rep%0d_lw", k),
           mkv(1, 1, 0, 1, lw, 32'h200 + 32'(k * 16), 1, 1, 0, 1, lw, 32'h200 + 32'(k * 16), NW'(k)));
      step($sformatf("rep%0d_bub", k),
           mkv(1, 1, 0, 1, u, 32'h204 + 32'(k * 16), 1, 0, 1, 0, '0, 32'h0, NW'(k + 1)));
      step($sformatf("rep%0d_use", k),
           mkv(1, 1, 0, 1, u, 32'h204 + 32'(k * 16), 1, 1, 0, 1, u, 32'h204 + 32'(k * 16), NW'(k + 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
